chuva_filtro: RTL

Upstream conditioning stage for the irrigation controller. Takes the raw 2-bit rain-sensor level from the switches, synchronises it, and debounces it on a divided sample tick. Delivers a stable `chuva` level to the irrigation FSM. Also flags a chattering sensor and counts heavy-rain episodes.

---
 rtl/chuva_filtro_if.sv | 15 +
 rtl/chuva_filtro.sv | 127 ++++++++++++
 2 files changed

// File: rtl/chuva_filtro_if.sv
// chuva_filtro_if: rain filter bundle (raw level and clear in, filtered level and status out).
//   chuva_raw[1:0], fault_clr      : driven by the sensor side (master)
//   chuva[1:0], chuva_upd, tick    : filtered level, update pulse, sample strobe (slave)
//   sensor_fault, forte_count[7:0] : sticky chatter flag, heavy-rain commit counter (slave)
interface chuva_filtro_if;
  logic [1:0] chuva_raw;
  logic       fault_clr;
  logic [1:0] chuva;
  logic       chuva_upd;
  logic       tick;
  logic       sensor_fault;
  logic [7:0] forte_count;
  modport master(output chuva_raw, fault_clr, input chuva, chuva_upd, tick, sensor_fault, forte_count);
  modport slave(input chuva_raw, fault_clr, output chuva, chuva_upd, tick, sensor_fault, forte_count);
endinterface

// File: rtl/chuva_filtro.sv
// chuva_filtro: synchronise and debounce the 2-bit rain sensor, flag chatter, count heavy-rain commits.
//   clk_2, reset_n (async, active low); bus: chuva_filtro_if.slave (see interface header).
//   Optional CHUVA_HIST_EN: falling commits need 2*STABLE_TICKS ticks.
module chuva_filtro #(
  parameter int DIV_BITS     = 2,
  parameter int STABLE_TICKS = 4,
  parameter int FAULT_LIMIT  = 6,
  parameter int WINDOW_TICKS = 16
) (
  input logic            clk_2,
  input logic            reset_n,
  chuva_filtro_if.slave  bus
);
`ifdef CHUVA_HIST_EN
  localparam int CW = 5;
  localparam int FALL_TICKS = 2 * STABLE_TICKS;
`else
  localparam int CW = 4;
  localparam int FALL_TICKS = STABLE_TICKS;
`endif
  typedef enum logic {STABLE, COUNT} state_t;
  state_t r_state, w_state;
  logic [DIV_BITS-1:0] r_div;
  logic r_tick, r_upd, r_fault, w_upd, w_fault, w_inc, w_wrap;
  logic [1:0] r_sync0, r_sync1, r_chuva, r_cand, w_chuva, w_cand;
  logic [CW-1:0] r_cnt, w_cnt, w_need;
  logic [7:0] r_win, w_win, r_forte, w_forte;
  logic [3:0] r_glitch, w_glitch, w_base;
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_tick   <= 1'b0;
      r_sync0  <= 2'b10;
      r_sync1  <= 2'b10;
      r_state  <= STABLE;
      r_chuva  <= 2'b10;
      r_cand   <= 2'b10;
      r_cnt    <= '0;
      r_upd    <= 1'b0;
      r_fault  <= 1'b0;
      r_win    <= '0;
      r_glitch <= '0;
      r_forte  <= '0;
    end else begin
      r_div    <= r_div + 1'b1;
      r_tick   <= &r_div;
      r_sync0  <= bus.chuva_raw;
      r_sync1  <= r_sync0;
      r_state  <= w_state;
      r_chuva  <= w_chuva;
      r_cand   <= w_cand;
      r_cnt    <= w_cnt;
      r_upd    <= w_upd;
      r_fault  <= w_fault;
      r_win    <= w_win;
      r_glitch <= w_glitch;
      r_forte  <= w_forte;
    end
  end
  // Falling commits take the longer run only when hysteresis is built in.
  assign w_need = (r_cand < r_chuva) ? CW'(FALL_TICKS - 1) : CW'(STABLE_TICKS - 1);
  always_comb begin
    w_state = r_state;
    w_cand  = r_cand;
    w_cnt   = r_cnt;
    w_chuva = r_chuva;
    w_upd   = 1'b0;
    w_fault = r_fault;
    w_forte = r_forte;
    w_inc   = 1'b0;
    w_wrap  = r_tick && (r_win == 8'(WINDOW_TICKS - 1));
    w_win   = r_tick ? (w_wrap ? 8'd0 : r_win + 8'd1) : r_win;
    if (r_tick) begin
      if (r_state == STABLE) begin
        if (r_sync1 != r_chuva) begin
          w_cand  = r_sync1;
          w_cnt   = CW'(1);
          w_state = COUNT;
        end
      end else if (r_sync1 == r_cand) begin
        if (r_cnt == w_need) begin
          w_state = STABLE;
          // A faulted sensor keeps chuva pinned at 3; the run is simply dropped.
          if (!r_fault) begin
            w_chuva = r_cand;
            w_upd   = 1'b1;
            w_forte = (r_cand == 2'd3 && r_chuva != 2'd3 && r_forte != 8'd255) ? r_forte + 8'd1 : r_forte;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end else if (r_sync1 == r_chuva) begin
        w_state = STABLE;
        w_inc   = 1'b1;
      end else begin
        w_cand = r_sync1;
        w_cnt  = CW'(1);
        w_inc  = 1'b1;
      end
    end
    // A glitch on the wrap tick is the first one of the new window; the count saturates at the limit.
    w_base   = w_wrap ? 4'd0 : r_glitch;
    w_glitch = w_base + {3'b000, w_inc && (w_base < 4'(FAULT_LIMIT))};
    if (w_inc && w_base == 4'(FAULT_LIMIT - 1)) begin
      w_fault = 1'b1;
      w_state = STABLE;
      w_chuva = 2'd3;
      w_upd   = r_chuva != 2'd3;
    end
    if (bus.fault_clr) begin
      w_fault  = 1'b0;
      w_glitch = '0;
      w_win    = '0;
      w_state  = STABLE;
      w_chuva  = r_chuva;
      w_upd    = 1'b0;
      w_forte  = r_forte;
    end
  end
  always_comb begin
    bus.chuva        = r_chuva;
    bus.chuva_upd    = r_upd;
    bus.tick         = r_tick;
    bus.sensor_fault = r_fault;
    bus.forte_count  = r_forte;
  end
endmodule
